prng_arbiter: RTL and testbench

//  Shares the single Trivium PRNG (prng_trivium_enhanced) among NREQ requesters (seed expander,
//  gen_a, binomial samplers, future encaps/decaps samplers) that today are muxed by top-level state.

---
 rtl/prng_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_prng_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prng_arbiter.sv
// prng_arbiter: shares one Trivium PRNG among NREQ requesters. One requester
// owns the PRNG at a time; seed/reseed/rdi handshakes are routed to the owner
// only. Ownership is never released while a reseed is outstanding.
// Arbitration: fixed priority (lowest index wins) by default; define
// PRNG_ARB_RR_EN for round-robin, where the search starts after the last owner.

// Per-requester routing slice: masks everything by the lane's grant bit.
module prng_arb_lane #(
    parameter int SEED_W = 256
) (
    input  logic              owned,
    input  logic              req_reseed,
    input  logic              req_ready,
    input  logic [SEED_W-1:0] req_seed,
    input  logic              prng_valid,
    input  logic              prng_ack,
    output logic              lane_reseed,
    output logic              lane_ready,
    output logic [SEED_W-1:0] lane_seed,
    output logic              lane_valid,
    output logic              lane_ack,
    output logic              rogue
);
    assign lane_reseed = owned & req_reseed;
    assign lane_ready  = owned & req_ready;
    assign lane_seed   = owned ? req_seed : '0;
    assign lane_valid  = owned & prng_valid;
    assign lane_ack    = owned & prng_ack;
    // A lane asking for a reseed without holding the grant is a protocol error.
    assign rogue       = req_reseed & ~owned;
endmodule

module prng_arbiter #(
    parameter int NREQ   = 3,
    parameter int SEED_W = 256,
    parameter int DATA_W = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    output logic [NREQ-1:0]        gnt,
    output logic                   busy,
    output logic                   proto_err,
    input  logic [NREQ*SEED_W-1:0] seed_in,
    input  logic [NREQ-1:0]        reseed_in,
    input  logic [NREQ-1:0]        rdi_ready_in,
    output logic [NREQ-1:0]        reseed_ack_o,
    output logic [NREQ-1:0]        rdi_valid_o,
    output logic [DATA_W-1:0]      rdi_data_o,
    output logic                   en_prng,
    output logic [SEED_W-1:0]      seed,
    output logic                   reseed,
    input  logic                   reseed_ack,
    input  logic [DATA_W-1:0]      rdi_data,
    input  logic                   rdi_valid,
    output logic                   rdi_ready
);
    typedef enum logic {IDLE, OWN} state_t;

    state_t                       state;
    logic                         reseed_pend;
    logic [NREQ-1:0][SEED_W-1:0]  seed_arr;
    logic [NREQ-1:0][SEED_W-1:0]  lane_seed;
    logic [NREQ-1:0]              lane_reseed;
    logic [NREQ-1:0]              lane_ready;
    logic [NREQ-1:0]              lane_valid;
    logic [NREQ-1:0]              lane_ack;
    logic [NREQ-1:0]              rogue;
    logic [NREQ-1:0]              win_oh;
    logic                         owner_req;
    logic                         pend_nxt;
    logic                         release_own;
    int                           cand;
`ifdef PRNG_ARB_RR_EN
    localparam int               IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NREQ - 1);
    logic [IDX_W-1:0]             rr_ptr;
    logic [IDX_W-1:0]             win_idx;
`endif

    assign seed_arr = seed_in;

    for (genvar i = 0; i < NREQ; i++) begin : gen_lane
        prng_arb_lane #(.SEED_W(SEED_W)) u_lane (
            .owned      (gnt[i]),
            .req_reseed (reseed_in[i]),
            .req_ready  (rdi_ready_in[i]),
            .req_seed   (seed_arr[i]),
            .prng_valid (rdi_valid),
            .prng_ack   (reseed_ack),
            .lane_reseed(lane_reseed[i]),
            .lane_ready (lane_ready[i]),
            .lane_seed  (lane_seed[i]),
            .lane_valid (lane_valid[i]),
            .lane_ack   (lane_ack[i]),
            .rogue      (rogue[i])
        );
    end

    // Merge lane seeds; at most the owner lane is non-zero, all zero when idle.
    always_comb begin
        seed = '0;
        for (int i = 0; i < NREQ; i++) seed = seed | lane_seed[i];
    end

    // PRNG side is driven only while owned (gnt is zero in IDLE).
    assign en_prng      = busy;
    assign reseed       = (|lane_reseed) | reseed_pend;
    assign rdi_ready    = |lane_ready;
    assign rdi_valid_o  = lane_valid;
    assign reseed_ack_o = lane_ack;
    assign rdi_data_o   = busy ? rdi_data : '0;

    // A reseed still unacknowledged after this edge keeps the owner in place,
    // including the very cycle it is first raised.
    assign pend_nxt    = reseed & ~reseed_ack;
    assign owner_req   = |(req & gnt);
    assign release_own = ~owner_req & ~pend_nxt;

    // Winner search: scan downward so the first candidate in priority order
    // is the last one written.
    always_comb begin
        win_oh = '0;
        cand   = 0;
`ifdef PRNG_ARB_RR_EN
        win_idx = '0;
`endif
        for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef PRNG_ARB_RR_EN
            cand = (int'(rr_ptr) + k) % NREQ;
`else
            cand = k;
`endif
            if (req[cand]) begin
                win_oh       = '0;
                win_oh[cand] = 1'b1;
`ifdef PRNG_ARB_RR_EN
                win_idx      = IDX_W'(cand);
`endif
            end
        end
    end

    // Ownership FSM: grant from IDLE, hold in OWN until owner lets go, then
    // spend one IDLE cycle before the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            gnt         <= '0;
            busy        <= 1'b0;
            reseed_pend <= 1'b0;
            proto_err   <= 1'b0;
`ifdef PRNG_ARB_RR_EN
            rr_ptr      <= '0;
`endif
        end else begin
            if (|rogue) proto_err <= 1'b1;
            case (state)
                IDLE: begin
                    reseed_pend <= 1'b0;
                    if (|req) begin
                        state <= OWN;
                        gnt   <= win_oh;
                        busy  <= 1'b1;
`ifdef PRNG_ARB_RR_EN
                        rr_ptr <= (win_idx == LAST) ? '0 : win_idx + 1'b1;
`endif
                    end
                end
                OWN: begin
                    reseed_pend <= pend_nxt;
                    if (release_own) begin
                        state <= IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    gnt         <= '0;
                    busy        <= 1'b0;
                    reseed_pend <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prng_arbiter.sv
// tb_prng_arbiter: directed scenarios plus random traffic, every cycle checked
// against an ownership-level reference model (owner index, pending reseed,
// search pointer, sticky error flag).
module tb_prng_arbiter;
    localparam int NREQ   = 3;
    localparam int SEED_W = 256;
    localparam int DATA_W = 128;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req, reseed_in, rdi_ready_in;
    logic [NREQ*SEED_W-1:0] seed_in;
    logic [NREQ-1:0]        gnt, reseed_ack_o, rdi_valid_o;
    logic                   busy, proto_err, en_prng, reseed, reseed_ack, rdi_valid, rdi_ready;
    logic [SEED_W-1:0]      seed;
    logic [DATA_W-1:0]      rdi_data, rdi_data_o;

    int n_chk = 0;
    int n_fail = 0;

    // reference model state
    int m_own;
    int m_ptr;
    bit m_pend;
    bit m_err;

    logic [NREQ-1:0] exp_seq [4];

    prng_arbiter #(.NREQ(NREQ), .SEED_W(SEED_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .busy(busy), .proto_err(proto_err),
        .seed_in(seed_in), .reseed_in(reseed_in), .rdi_ready_in(rdi_ready_in),
        .reseed_ack_o(reseed_ack_o), .rdi_valid_o(rdi_valid_o), .rdi_data_o(rdi_data_o),
        .en_prng(en_prng), .seed(seed), .reseed(reseed), .reseed_ack(reseed_ack),
        .rdi_data(rdi_data), .rdi_valid(rdi_valid), .rdi_ready(rdi_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NREQ*SEED_W-1:0] rnd_seeds();
        logic [NREQ*SEED_W-1:0] s;
        for (int i = 0; i < NREQ * SEED_W / 32; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    task automatic m_reset();
        m_own  = -1;
        m_ptr  = 0;
        m_pend = 1'b0;
        m_err  = 1'b0;
    endtask

    // Compare all outputs with what the model says the owner should see now.
    task automatic cmp_all();
        logic [NREQ-1:0]   eg;
        logic [SEED_W-1:0] es;
        logic              er, ey;
        logic [DATA_W-1:0] ed;
        eg = '0; es = '0; er = 1'b0; ey = 1'b0; ed = '0;
        if (m_own >= 0) begin
            eg[m_own] = 1'b1;
            es = seed_in[m_own*SEED_W +: SEED_W];
            er = reseed_in[m_own] | m_pend;
            ey = rdi_ready_in[m_own];
            ed = rdi_data;
        end
        chk("gnt",     256'(gnt),          256'(eg));
        chk("busy",    256'(busy),         256'(m_own >= 0));
        chk("en_prng", 256'(en_prng),      256'(m_own >= 0));
        chk("perr",    256'(proto_err),    256'(m_err));
        chk("seed",    256'(seed),         256'(es));
        chk("reseed",  256'(reseed),       256'(er));
        chk("rdy",     256'(rdi_ready),    256'(ey));
        chk("vld_o",   256'(rdi_valid_o),  256'(rdi_valid ? eg : '0));
        chk("ack_o",   256'(reseed_ack_o), 256'(reseed_ack ? eg : '0));
        chk("data_o",  256'(rdi_data_o),   256'(ed));
    endtask

    // Advance the model across one clock edge using the inputs held at it.
    task automatic model_tick();
        bit pn;
        for (int i = 0; i < NREQ; i++)
            if (reseed_in[i] && i != m_own) m_err = 1'b1;
        if (m_own < 0) begin
            m_pend = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (req[c]) begin
                    m_own = c;
                    break;
                end
            end
`ifdef PRNG_ARB_RR_EN
            if (m_own >= 0) m_ptr = (m_own + 1) % NREQ;
`endif
        end else begin
            pn = (reseed_in[m_own] | m_pend) & ~reseed_ack;
            m_pend = pn;
            if (!req[m_own] && !pn) m_own = -1;
        end
    endtask

    // One cycle: check settled outputs, cross the edge, land on next negedge.
    task automatic step();
        #1;
        cmp_all();
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_gnt",  256'(gnt),  256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        @(negedge clk);
        m_reset();
        rst = 1'b0;
    endtask

    initial begin
`ifdef PRNG_ARB_RR_EN
        exp_seq = '{3'b001, 3'b100, 3'b001, 3'b100};
`else
        exp_seq = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
        rst = 1'b1;
        req = '0; reseed_in = '0; rdi_ready_in = '0;
        seed_in = rnd_seeds();
        reseed_ack = 1'b0; rdi_valid = 1'b0; rdi_data = '0;
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst_gnt",    256'(gnt),         256'(0));
        chk("rst_busy",   256'(busy),        256'(0));
        chk("rst_perr",   256'(proto_err),   256'(0));
        chk("rst_en",     256'(en_prng),     256'(0));
        chk("rst_reseed", 256'(reseed),      256'(0));
        chk("rst_seed",   256'(seed),        256'(0));
        chk("rst_vld",    256'(rdi_valid_o), 256'(0));
        rst = 1'b0;

        // single requester, four words
        req = 3'b010; rdi_ready_in = 3'b010;
        step();
        chk("t1_gnt",  256'(gnt),  256'(3'b010));
        chk("t1_busy", 256'(busy), 256'(1));
        chk("t1_seed", 256'(seed), 256'(seed_in[SEED_W +: SEED_W]));
        for (int w = 0; w < 4; w++) begin
            rdi_valid = 1'b1;
            rdi_data = {$urandom, $urandom, $urandom, $urandom};
            #1;
            chk("t1_word", 256'(rdi_valid_o), 256'(3'b010));
            step();
        end
        rdi_valid = 1'b0; req = '0;
        step(); step();

        // contention: owner 0 drops, one dead cycle, then requester 1
        do_reset();
        req = 3'b111;
        step();
        chk("t2_gnt0", 256'(gnt), 256'(3'b001));
        step();
        req = 3'b110;
        step();
        chk("t2_dead", 256'(gnt), 256'(0));
        step();
        chk("t2_gnt1", 256'(gnt), 256'(3'b010));
        req = '0;
        step(); step();

        // fairness between requesters 0 and 2
        do_reset();
        req = 3'b101; rdi_ready_in = 3'b111;
        for (int g = 0; g < 4; g++) begin
            step();
            chk($sformatf("t3_seq%0d", g), 256'(gnt), 256'(exp_seq[g]));
            rdi_valid = 1'b1;
            step(); step();
            rdi_valid = 1'b0;
            if (m_own >= 0) req[m_own] = 1'b0;
            step();
            req = 3'b101;
        end
        req = '0;
        step(); step();

        // reseed outstanding holds the grant after req drops
        req = 3'b100;
        step();
        reseed_in = 3'b100;
        step();
        req = '0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t4_hold",   256'(gnt),    256'(3'b100));
            chk("t4_reseed", 256'(reseed), 256'(1));
            step();
        end
        reseed_ack = 1'b1;
        #1;
        chk("t4_ack", 256'(reseed_ack_o), 256'(3'b100));
        step();
        reseed_ack = 1'b0; reseed_in = '0;
        chk("t4_idle", 256'(gnt), 256'(0));
        step();

        // random traffic, only owners reseed
        for (int c = 0; c < 600; c++) begin
            req = NREQ'($urandom_range(0, 7));
            if (m_own >= 0 && $urandom_range(0, 3) != 0) req[m_own] = 1'b1;
            reseed_in = '0;
            if (m_own >= 0 && $urandom_range(0, 2) == 0) reseed_in[m_own] = 1'b1;
            reseed_ack = ($urandom_range(0, 3) == 0);
            rdi_valid = 1'($urandom_range(0, 1));
            rdi_ready_in = NREQ'($urandom_range(0, 7));
            rdi_data = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 15) == 0) seed_in = rnd_seeds();
            step();
        end

        // drain any pending reseed, then protocol error and async reset
        req = '0; reseed_in = '0; rdi_valid = 1'b0; reseed_ack = 1'b1;
        step(); step();
        reseed_ack = 1'b0;
        step();
        req = 3'b010;
        step();
        chk("t5_own", 256'(gnt), 256'(3'b010));
        reseed_in = 3'b001;
        #1;
        chk("t5_noreseed", 256'(reseed), 256'(0));
        step();
        reseed_in = '0;
        chk("t5_perr", 256'(proto_err), 256'(1));
        step();
        chk("t5_sticky", 256'(proto_err), 256'(1));
        rdi_valid = 1'b1;
        #3 rst = 1'b1;
        #1;
        chk("t5_rst_gnt",  256'(gnt),         256'(0));
        chk("t5_rst_en",   256'(en_prng),     256'(0));
        chk("t5_rst_busy", 256'(busy),        256'(0));
        chk("t5_rst_vld",  256'(rdi_valid_o), 256'(0));
        chk("t5_rst_perr", 256'(proto_err),   256'(0));
        @(negedge clk);
        m_reset();
        rst = 1'b0; req = '0; rdi_valid = 1'b0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
